// File: rtl/relu_backprop.sv
// ReLU backward-pass gradient gate with an in-order forward mask FIFO.
// Optional leaky negative side is enabled by defining RELU_BP_LEAKY_EN.
module relu_backprop #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     fwd_valid,
    output logic                     fwd_ready,
    input  logic [WIDTH-1:0]         fwd_in,
    input  logic                     grad_valid,
    output logic                     grad_ready,
    input  logic [WIDTH-1:0]         grad_in,
    output logic                     gout_valid,
    input  logic                     gout_ready,
    output logic [WIDTH-1:0]         gout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [DEPTH-1:0] mask_q, mask_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             gout_valid_q, gout_valid_d;
    logic [WIDTH-1:0] gout_q, gout_d;
    logic             push, pop, fwd_mask, cur_mask;
    logic [WIDTH-1:0] gated;

    assign grad_ready = (level_q != '0) && (!gout_valid_q || gout_ready);
    assign pop        = grad_valid && grad_ready;
    assign fwd_ready  = (level_q != FULL) || pop;
    assign push       = fwd_valid && fwd_ready;

    // x > 0: sign clear and not zero
    assign fwd_mask = !fwd_in[WIDTH-1] && (fwd_in != '0);
    assign cur_mask = mask_q[rptr_q];

`ifdef RELU_BP_LEAKY_EN
    assign gated = cur_mask ? grad_in : ($signed(grad_in) >>> LEAK_SHIFT);
`else
    assign gated = cur_mask ? grad_in : '0;
`endif

    always_comb begin
        mask_d       = mask_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        level_d      = level_q;
        gout_valid_d = gout_valid_q;
        gout_d       = gout_q;
        if (flush) begin
            wptr_d       = '0;
            rptr_d       = '0;
            level_d      = '0;
            gout_valid_d = 1'b0;
            gout_d       = '0;
        end else begin
            if (push) begin
                mask_d[wptr_q] = fwd_mask;
                wptr_d         = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d       = rptr_q + 1'b1;
                gout_d       = gated;
                gout_valid_d = 1'b1;
            end else if (gout_ready) begin
                gout_valid_d = 1'b0;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            gout_valid_q <= 1'b0;
            gout_q       <= '0;
        end else begin
            mask_q       <= mask_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            gout_valid_q <= gout_valid_d;
            gout_q       <= gout_d;
        end
    end

    assign gout_valid = gout_valid_q;
    assign gout       = gout_q;
    assign level      = level_q;
endmodule
